// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: RISC-V opcodes, FSM state
// type, operand-usage record and the decode function that produces it.
package hazard_pkg;

    // Major opcodes (instr[6:0]) relevant to operand-usage decode
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    // Wide enough to hold the largest stall/flush length (3)
    localparam int unsigned CNT_W = $clog2(3) + 1;

    typedef enum logic [1:0] {
        StRun,
        StLstall,
        StFlush
    } state_t;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } opnd_use_t;

    // Which source-register fields an instruction actually reads
    function automatic opnd_use_t decode_use(input logic [31:0] instr);
        opnd_use_t u;
        u = '0;
        case (instr[6:0])
            LUI, AUIPC, JAL: u = '0;
            OP_IMM, LOAD, JALR, SYSTEM: u.rs1 = 1'b1;
            OP, BRANCH, STORE: begin
                u.rs1 = 1'b1;
                u.rs2 = 1'b1;
            end
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard unit bundle. The pipeline side is the master (drives
// instruction/writeback info), the hazard unit is the slave.
interface hazard_ctrl_unit_if #(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned SELW    = $clog2(NUM_FWD + 1)
);
    logic [31:0]              instr_d;
    logic [31:0]              instr_x;
    logic [NUM_FWD-1:0][4:0]  src_rd;
    logic [NUM_FWD-1:0]       src_we;
    logic                     br_taken;
    logic [SELW-1:0]          fwd_a_sel;
    logic [SELW-1:0]          fwd_b_sel;
    logic                     stall;
    logic                     flush;

    modport master (
        output instr_d, instr_x, src_rd, src_we, br_taken,
        input  fwd_a_sel, fwd_b_sel, stall, flush
    );

    modport slave (
        input  instr_d, instr_x, src_rd, src_we, br_taken,
        output fwd_a_sel, fwd_b_sel, stall, flush
    );
endinterface

// File: rtl/fwd_mux_sel.sv
// Priority forwarding select for one execute operand: picks the youngest
// (lowest-index) writing source whose non-zero rd matches the operand.
module fwd_mux_sel #(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned SELW    = $clog2(NUM_FWD + 1)
) (
    input  logic [4:0]             i_rs,
    input  logic [NUM_FWD-1:0][4:0] i_src_rd,
    input  logic [NUM_FWD-1:0]     i_src_we,
    output logic [SELW-1:0]        o_sel
);

    // Scan oldest to youngest so the youngest match is the last write
    always_comb begin
        o_sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_src_we[k] && (i_src_rd[k] != 5'd0) && (i_src_rd[k] == i_rs)) begin
                o_sel = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: operand forwarding selects plus a small FSM that produces
// load-use stalls and post-branch flushes of fixed length.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NUM_FWD     = 2,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned SELW        = $clog2(NUM_FWD + 1)
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_stall;
    logic             w_flush;
    logic             w_hazard;
    opnd_use_t        w_use;
    logic [4:0]       w_x_rd;
    logic             w_x_is_load;

    // Forwarding for both execute operands
    fwd_mux_sel #(
        .NUM_FWD (NUM_FWD),
        .SELW    (SELW)
    ) u_fwd_a (
        .i_rs     (bus.instr_x[19:15]),
        .i_src_rd (bus.src_rd),
        .i_src_we (bus.src_we),
        .o_sel    (bus.fwd_a_sel)
    );

    fwd_mux_sel #(
        .NUM_FWD (NUM_FWD),
        .SELW    (SELW)
    ) u_fwd_b (
        .i_rs     (bus.instr_x[24:20]),
        .i_src_rd (bus.src_rd),
        .i_src_we (bus.src_we),
        .o_sel    (bus.fwd_b_sel)
    );

    // Load-use detection: only fields the decode instruction really reads count
    always_comb begin
        w_use       = decode_use(bus.instr_d);
        w_x_rd      = bus.instr_x[11:7];
        w_x_is_load = (bus.instr_x[6:0] == LOAD);
        w_hazard    = w_x_is_load && (w_x_rd != 5'd0) &&
                      ((w_use.rs1 && (w_x_rd == bus.instr_d[19:15])) ||
                       (w_use.rs2 && (w_x_rd == bus.instr_d[24:20])));
    end

    // Next-state and raw stall/flush; a taken branch always beats a stall
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_stall   = 1'b0;
        w_flush   = 1'b0;
        unique case (r_state)
            StRun: begin
                if (bus.br_taken) begin
                    w_flush = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        w_state_d = StFlush;
                        w_cnt_d   = FLUSH_RELOAD;
                    end
                end else if (w_hazard) begin
                    w_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_d = StLstall;
                        w_cnt_d   = LOAD_RELOAD;
                    end
                end
            end
            StLstall: begin
                if (bus.br_taken) begin
                    // Abandon the remaining stall; the load is being killed anyway
                    w_flush = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        w_state_d = StFlush;
                        w_cnt_d   = FLUSH_RELOAD;
                    end else begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                    end
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt <= CNT_ONE) begin
                        w_state_d = StRun;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt - CNT_ONE;
                    end
                end
            end
            StFlush: begin
                w_flush = 1'b1;
                if (bus.br_taken) begin
                    w_cnt_d = FLUSH_RELOAD;
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_d = StRun;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Reset masks the control outputs immediately, not just at the next edge
    assign bus.stall = w_stall & ~rst;
    assign bus.flush = w_flush & ~rst;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: three hazard units with different parameters share one
// stimulus stream; expected values are hand-derived per cycle.
module tb_hazard_ctrl_unit;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] LW_X7        = 32'h0000_A383; // lw x7,0(x1)
    localparam logic [31:0] LW_X3        = 32'h0000_A183; // lw x3,0(x1)
    localparam logic [31:0] LW_X0        = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] ADD_X1_X7_X2 = 32'h0023_80B3;
    localparam logic [31:0] ADD_X1_X0_X0 = 32'h0000_00B3;
    localparam logic [31:0] ADD_X7_X1_X2 = 32'h0020_83B3;
    localparam logic [31:0] ADD_X1_X5_X6 = 32'h0062_80B3;
    localparam logic [31:0] LUI_X7       = 32'h0003_83B7; // rs1 field = 7
    localparam logic [31:0] ADDI_X1_X0_3 = 32'h0030_0093; // rs2 field = 3
    localparam logic [31:0] ADDI_X1_X3_0 = 32'h0001_8093;
    localparam logic [31:0] SW_X7        = 32'h0070_A023; // sw x7,0(x1)
    localparam logic [31:0] UNK_OPC      = 32'h0073_807F; // rs1=rs2=7

    localparam int DA = 0; // NUM_FWD=2 LOAD_LAT=2 FLUSH_DEPTH=3
    localparam int DB = 1; // NUM_FWD=3 LOAD_LAT=3 FLUSH_DEPTH=2
    localparam int DC = 2; // NUM_FWD=1 LOAD_LAT=1 FLUSH_DEPTH=1

    logic             clk;
    logic             rst;
    logic [31:0]      instr_d;
    logic [31:0]      instr_x;
    logic [2:0][4:0]  src_rd;
    logic [2:0]       src_we;
    logic             br_taken;

    int n_tests;
    int n_fail;

    hazard_ctrl_unit_if #(.NUM_FWD(2)) if_a ();
    hazard_ctrl_unit_if #(.NUM_FWD(3)) if_b ();
    hazard_ctrl_unit_if #(.NUM_FWD(1)) if_c ();

    assign if_a.instr_d  = instr_d;
    assign if_a.instr_x  = instr_x;
    assign if_a.src_rd   = src_rd[1:0];
    assign if_a.src_we   = src_we[1:0];
    assign if_a.br_taken = br_taken;
    assign if_b.instr_d  = instr_d;
    assign if_b.instr_x  = instr_x;
    assign if_b.src_rd   = src_rd;
    assign if_b.src_we   = src_we;
    assign if_b.br_taken = br_taken;
    assign if_c.instr_d  = instr_d;
    assign if_c.instr_x  = instr_x;
    assign if_c.src_rd   = src_rd[0:0];
    assign if_c.src_we   = src_we[0:0];
    assign if_c.br_taken = br_taken;

    hazard_ctrl_unit #(.NUM_FWD(2), .LOAD_LAT(2), .FLUSH_DEPTH(3)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    hazard_ctrl_unit #(.NUM_FWD(3), .LOAD_LAT(3), .FLUSH_DEPTH(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );
    hazard_ctrl_unit #(.NUM_FWD(1), .LOAD_LAT(1), .FLUSH_DEPTH(1)) u_dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_sf(input string tag, input int d, input bit es, input bit ef);
        logic s;
        logic f;
        string nm;
        case (d)
            DA:      begin s = if_a.stall; f = if_a.flush; nm = "a_"; end
            DB:      begin s = if_b.stall; f = if_b.flush; nm = "b_"; end
            default: begin s = if_c.stall; f = if_c.flush; nm = "c_"; end
        endcase
        check({nm, tag, "_stall"}, 32'(s), 32'(es));
        check({nm, tag, "_flush"}, 32'(f), 32'(ef));
    endtask

    // Inputs change just after the rising edge, checks happen on the falling edge
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_all();
        rst = 1'b1;
        br_taken = 1'b0;
        instr_d = NOP;
        instr_x = NOP;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset held with a branch and a load-use hazard present
        rst      = 1'b1;
        br_taken = 1'b1;
        instr_x  = LW_X7;
        instr_d  = ADD_X1_X7_X2;
        src_rd   = '0;
        src_rd[0] = 5'd1;
        src_we   = 3'b001;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("rst", d, 1'b0, 1'b0);
        check("rst_fwd_a", 32'(if_a.fwd_a_sel), 1);
        nxt();
        nxt();
        rst = 1'b0; br_taken = 1'b0; instr_x = NOP; instr_d = NOP; src_we = '0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("post_rst", d, 1'b0, 1'b0);
        nxt();

        // Forwarding priority
        instr_x = ADD_X1_X5_X6;
        src_rd[0] = 5'd5; src_rd[1] = 5'd5; src_rd[2] = 5'd0; src_we = 3'b011;
        #2;
        check("fwd_both_a", 32'(if_a.fwd_a_sel), 1);
        check("fwd_both_b", 32'(if_b.fwd_a_sel), 1);
        check("fwd_both_c", 32'(if_c.fwd_a_sel), 1);
        check("fwd_both_a_rs2", 32'(if_a.fwd_b_sel), 0);
        src_we = 3'b010;
        #2;
        check("fwd_we0_off_a", 32'(if_a.fwd_a_sel), 2);
        check("fwd_we0_off_b", 32'(if_b.fwd_a_sel), 2);
        check("fwd_we0_off_c", 32'(if_c.fwd_a_sel), 0);
        src_rd[0] = 5'd0; src_rd[1] = 5'd0; src_we = 3'b011;
        #2;
        check("fwd_rd0_a", 32'(if_a.fwd_a_sel), 0);
        check("fwd_rd0_b", 32'(if_b.fwd_a_sel), 0);
        src_rd[0] = 5'd5; src_rd[1] = 5'd6;
        #2;
        check("fwd_split_a_rs1", 32'(if_a.fwd_a_sel), 1);
        check("fwd_split_a_rs2", 32'(if_a.fwd_b_sel), 2);
        src_rd[0] = 5'd0; src_rd[1] = 5'd0; src_rd[2] = 5'd5; src_we = 3'b100;
        #2;
        check("fwd_oldest_a", 32'(if_a.fwd_a_sel), 0);
        check("fwd_oldest_b", 32'(if_b.fwd_a_sel), 3);
        src_we = '0;
        nxt();

        // Load-use stall lengths
        instr_x = LW_X7; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("lu_c1", d, 1'b1, 1'b0);
        nxt();
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("lu_c2", d, 1'b1, 1'b0);
        nxt();
        instr_x = NOP;
        @(negedge clk);
        chk_sf("lu_c3", DA, 1'b0, 1'b0);
        chk_sf("lu_c3", DB, 1'b1, 1'b0);
        chk_sf("lu_c3", DC, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("lu_c4", DB, 1'b0, 1'b0);
        nxt();

        // Operand-usage decode cases
        instr_x = LW_X7; instr_d = LUI_X7;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("lui", d, 1'b0, 1'b0);
        nxt();
        instr_x = LW_X3; instr_d = ADDI_X1_X0_3;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("addi_imm", d, 1'b0, 1'b0);
        nxt();
        instr_x = LW_X7; instr_d = UNK_OPC;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("unk_opc", d, 1'b0, 1'b0);
        nxt();
        instr_x = LW_X0; instr_d = ADD_X1_X0_X0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("load_x0", d, 1'b0, 1'b0);
        nxt();
        instr_x = ADD_X7_X1_X2; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("non_load", d, 1'b0, 1'b0);
        nxt();
        instr_x = LW_X7; instr_d = SW_X7;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("store_rs2", d, 1'b1, 1'b0);
        nxt();
        rst_all();
        instr_x = LW_X3; instr_d = ADDI_X1_X3_0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("addi_rs1", d, 1'b1, 1'b0);
        nxt();
        rst_all();

        // Isolated branch flush lengths
        br_taken = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("br_c1", d, 1'b0, 1'b1);
        nxt();
        br_taken = 1'b0;
        @(negedge clk);
        chk_sf("br_c2", DA, 1'b0, 1'b1);
        chk_sf("br_c2", DB, 1'b0, 1'b1);
        chk_sf("br_c2", DC, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("br_c3", DA, 1'b0, 1'b1);
        chk_sf("br_c3", DB, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("br_c4", DA, 1'b0, 1'b0);
        nxt();

        // Second branch inside the flush window restarts it
        br_taken = 1'b1;
        nxt();
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("rebr_c2", d, 1'b0, 1'b1);
        nxt();
        br_taken = 1'b0;
        @(negedge clk);
        chk_sf("rebr_c3", DA, 1'b0, 1'b1);
        chk_sf("rebr_c3", DB, 1'b0, 1'b1);
        chk_sf("rebr_c3", DC, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("rebr_c4", DA, 1'b0, 1'b1);
        chk_sf("rebr_c4", DB, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("rebr_c5", DA, 1'b0, 1'b0);
        nxt();

        // Branch during a load stall wins and cancels the remaining stall
        instr_x = LW_X7; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        chk_sf("lsbr_c1", DB, 1'b1, 1'b0);
        nxt();
        br_taken = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("lsbr_c2", d, 1'b0, 1'b1);
        nxt();
        br_taken = 1'b0;
        @(negedge clk);
        chk_sf("lsbr_c3", DA, 1'b0, 1'b1);
        chk_sf("lsbr_c3", DB, 1'b0, 1'b1);
        nxt();
        instr_x = NOP; instr_d = NOP;
        @(negedge clk);
        chk_sf("lsbr_c4", DA, 1'b0, 1'b1);
        chk_sf("lsbr_c4", DB, 1'b0, 1'b0);
        nxt();
        @(negedge clk);
        chk_sf("lsbr_c5", DA, 1'b0, 1'b0);
        nxt();

        // Reset in the middle of a flush
        br_taken = 1'b1;
        @(negedge clk);
        chk_sf("rfl_c1", DA, 1'b0, 1'b1);
        nxt();
        br_taken = 1'b0; rst = 1'b1; instr_x = LW_X7; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_sf("rfl_c2", d, 1'b0, 1'b0);
        nxt();
        rst = 1'b0; instr_x = NOP; instr_d = NOP;
        @(negedge clk);
        chk_sf("rfl_c3", DA, 1'b0, 1'b0);
        chk_sf("rfl_c3", DB, 1'b0, 1'b0);
        nxt();
        instr_x = LW_X7; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        chk_sf("rfl_c4", DA, 1'b1, 1'b0);
        nxt();
        rst_all();

        // Reset in the middle of a load stall
        instr_x = LW_X7; instr_d = ADD_X1_X7_X2;
        @(negedge clk);
        chk_sf("rls_c1", DB, 1'b1, 1'b0);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk_sf("rls_c2", DB, 1'b0, 1'b0);
        nxt();
        rst = 1'b0; instr_x = NOP; instr_d = NOP;
        @(negedge clk);
        chk_sf("rls_c3", DB, 1'b0, 1'b0);
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
